a_stim_driver: RTL
==================

// Module: a_stim_driver
// PURPOSE
//   Serial stimulus transmitter for the single-bit input A of the fsm block.
//   Takes a WIDTH-bit pattern over a valid/ready load port and shifts it onto A, MSB first.
//   It can replay the pattern a programmable number of times, with a fixed idle gap between bursts.
//   Sits in front of fsm so that A sequences are generated from RTL, not from hand-timed delays.
// PARAMETERS
//   WIDTH  8  pattern length in bits (>=2)
//   CNT_W  4  width of the repeat-count field
//   GAP    2  idle cycles between repeated bursts (0 = back-to-back)
// PORTS
//   clock         in   1      rising-edge clock
//   reset         in   1      asynchronous, active-high reset
//   load_valid    in   1      pattern/repeat offered
//   load_ready    out  1      1 only in IDLE while reset is low
//   load_pattern  in   WIDTH  bits to transmit; bit WIDTH-1 goes first
//   load_repeat   in   CNT_W  extra replays (0 = send once)
//   abort         in   1      synchronous cancel
//   A             out  1      serial data to fsm.A
//   a_valid       out  1      1 when A carries a pattern bit
//   busy          out  1      1 in SHIFT or GAP
//   done          out  1      one-cycle pulse after the final bit
// BEHAVIOUR
//   Reset (async): state=IDLE; A, a_valid, busy and done all 0; load_ready=0 while reset is high.
//   Transfer: load_valid&&load_ready at edge k.
//     - Captures the pattern into a shadow register and the shift register.
//     - Captures load_repeat into rep_left.
//   SHIFT state (cycles k+1..k+WIDTH):
//     - A=shift[WIDTH-1], a_valid=1; shift left by one each cycle.
//     - A 0..WIDTH-1 bit counter runs alongside.
//   End of the last SHIFT cycle:
//     - rep_left>0 and GAP>0: go to GAP; rep_left decrements.
//     - rep_left>0 and GAP=0: reload from shadow and stay in SHIFT; rep_left decrements.
//     - rep_left==0: go to DONE.
//   GAP state:
//     - Lasts GAP cycles with A=0, a_valid=0, busy=1.
//     - Then returns to SHIFT, reloaded from shadow.
//   DONE state: lasts one cycle with done=1, A=0, busy=0; then IDLE.
//     - load_ready=1 from cycle k+WIDTH+2 for a single burst.
//   Outputs are registered; A is 0 whenever a_valid=0.
//   load_valid outside IDLE: ignored; no state change and nothing captured.
//   abort=1 at any edge: next state IDLE, A=0, a_valid=0, no done pulse.
//     - abort takes priority over a simultaneous load handshake.
//   Reset mid-burst: outputs clear immediately (no clock needed); the pattern is discarded.
//   rep_left never wraps; it decrements only while >0.
//   Total burst cycles = (load_repeat+1)*WIDTH + load_repeat*GAP.
// CONFIGURATION
//   PATTERN_LOOP_EN defined:
//     - Adds input port loop_en (1 bit).
//     - If loop_en=1 when rep_left==0 at the end of SHIFT, go to GAP (or straight to SHIFT if GAP=0).
//     - rep_left reloads from the captured load_repeat; done is not pulsed.
//     - Runs until abort or reset. loop_en=0 then lets the current pass finish normally with done.
//   PATTERN_LOOP_EN undefined: no loop_en port; every transfer ends in DONE.
// TESTING (WIDTH=8, CNT_W=4, GAP=2)
//   1. reset 20ns, then load 8'b1011_0001, repeat=0 at edge k.
//      -> A=1,0,1,1,0,0,0,1 on k+1..k+8, a_valid=1 there.
//      -> done=1 at k+9; load_ready=1 at k+10.
//   2. load 8'hF0, repeat=2.
//      -> three 1111_0000 bursts, each pair separated by 2 cycles of A=0/a_valid=0.
//      -> 28 busy cycles; done at k+29.
//   3. During scenario 2, hold load_valid=1 with 8'h55 from the third SHIFT cycle.
//      -> no effect; stream identical; 8'h55 accepted only at k+30.
//   4. load 8'hFF, assert abort on the 4th SHIFT cycle.
//      -> next cycle A=0, a_valid=0, busy=0, load_ready=1; done never pulses.
//   5. Assert reset async in mid-burst, between clock edges.
//      -> A, a_valid, busy and load_ready go to 0 before the next edge.
//      -> after release, IDLE with load_ready=1.
//   6. PATTERN_LOOP_EN, loop_en=1, load 8'hA5, repeat=0.
//      -> 1010_0101 repeats every 10 cycles with no done.
//      -> abort stops it within 1 cycle.

Source files
------------

// File: rtl/a_stim_driver.sv
// a_stim_driver: serial stimulus transmitter driving the single-bit A input of fsm, MSB first.
// Latency: first bit appears the cycle after the load handshake; done pulses the cycle after the last bit.
// Backpressure: load_ready is high only in IDLE, so loads offered mid-burst are held off untouched.
// Optional feature macro: PATTERN_LOOP_EN adds loop_en for endless replay until abort/reset.
module a_stim_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_pattern,
  input  logic [CNT_W-1:0] load_repeat,
  input  logic             abort,
`ifdef PATTERN_LOOP_EN
  input  logic             loop_en,
`endif
  output logic             A,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             a_q, a_d;
  logic             a_valid_q, a_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Loop support: keep the original repeat count so each loop pass replays it.
  logic             loop_act;
  logic [CNT_W-1:0] rep_reload;
`ifdef PATTERN_LOOP_EN
  logic [CNT_W-1:0] rep_load_q, rep_load_d;
  assign loop_act   = loop_en;
  assign rep_reload = rep_load_q;
`else
  assign loop_act   = 1'b0;
  assign rep_reload = '0;
`endif

  // Ready is a pure function of state, forced low while reset is held.
  assign load_ready = (state_q == S_IDLE) && !reset;

  assign A       = a_q;
  assign a_valid = a_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Next-state logic; abort overrides everything including a pending load.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
`ifdef PATTERN_LOOP_EN
    rep_load_d = rep_load_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            state_d  = S_SHIFT;
            shift_d  = load_pattern;
            shadow_d = load_pattern;
            bit_d    = '0;
            rep_d    = load_repeat;
`ifdef PATTERN_LOOP_EN
            rep_load_d = load_repeat;
`endif
          end
        end
        S_SHIFT: begin
          if (bit_q == BW'(WIDTH - 1)) begin
            if ((rep_q != '0) || loop_act) begin
              // Another pass: consume one repeat, or restart the count when looping.
              rep_d = (rep_q != '0) ? (rep_q - 1'b1) : rep_reload;
              if (GAP > 0) begin
                state_d = S_GAP;
                gap_d   = '0;
              end else begin
                shift_d = shadow_q;
                bit_d   = '0;
              end
            end else begin
              state_d = S_DONE;
            end
          end else begin
            shift_d = shift_q << 1;
            bit_d   = bit_q + 1'b1;
          end
        end
        S_GAP: begin
          if (int'(gap_q) >= GAP - 1) begin
            state_d = S_SHIFT;
            shift_d = shadow_q;
            bit_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    // Outputs are derived from the next state so they are registered with it.
    a_valid_d = (state_d == S_SHIFT);
    a_d       = (state_d == S_SHIFT) && shift_d[WIDTH-1];
    busy_d    = (state_d == S_SHIFT) || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers, cleared asynchronously so outputs drop without a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      shadow_q  <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      rep_q     <= '0;
      a_q       <= 1'b0;
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      rep_q     <= rep_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef PATTERN_LOOP_EN
  // Captured repeat count used to restart each loop pass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_load_q <= '0;
    end else begin
      rep_load_q <= rep_load_d;
    end
  end
`endif

endmodule
